// File: rtl/synch_neuron_pkg.sv
// Shared types for the neuron cluster: event opcodes and the accepted-event payload.
// Payload fields use the widest supported sizes; the cluster narrows them on use.
package synch_neuron_pkg;

  localparam int unsigned MAX_ADDR_W   = 8;
  localparam int unsigned MAX_WEIGHT_W = 16;
  localparam int unsigned SCALE_W      = 3;
  localparam int unsigned LEAK_W       = 4;

  typedef enum logic [1:0] {
    INTEGRATE = 2'd0,
    LEAK      = 2'd1,
    CLEAR     = 2'd2,
    NOP       = 2'd3
  } op_e;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0]   addr;
    op_e                     op;
    logic [MAX_WEIGHT_W-1:0] weight;
    logic [SCALE_W-1:0]      scale;
  } evt_t;

endpackage

// File: rtl/lif_update.sv
// Combinational leaky integrate-and-fire update for one neuron state.
// Produces the next stored state and whether the neuron fires.
module lif_update
  import synch_neuron_pkg::*;
#(
  parameter int unsigned STATE_WIDTH = 16
) (
  input  logic signed [STATE_WIDTH-1:0]  state,
  input  op_e                            op,
  input  logic signed [MAX_WEIGHT_W-1:0] weight,
  input  logic        [SCALE_W-1:0]      scale,
  input  logic signed [STATE_WIDTH-1:0]  threshold,
  input  logic        [LEAK_W-1:0]       leak_shift,
  output logic signed [STATE_WIDTH-1:0]  next_state_c,
  output logic                           fire_c
);

  // Wide enough to hold state plus a fully shifted weight without wrapping.
  localparam int unsigned SHIFTED_W = MAX_WEIGHT_W + (1 << SCALE_W) - 1;
  localparam int unsigned EXT_W     = ((STATE_WIDTH > SHIFTED_W) ? STATE_WIDTH : SHIFTED_W) + 1;

  localparam logic signed [STATE_WIDTH-1:0] S_MAX = {1'b0, {(STATE_WIDTH-1){1'b1}}};
  localparam logic signed [STATE_WIDTH-1:0] S_MIN = {1'b1, {(STATE_WIDTH-1){1'b0}}};

  logic signed [EXT_W-1:0]       sum;
  logic signed [STATE_WIDTH-1:0] sat;
  logic signed [STATE_WIDTH-1:0] leaked;

  // Saturating integrate and leak datapaths.
  always_comb begin
    sum = EXT_W'(state) + (EXT_W'(weight) <<< scale);
    if (sum > EXT_W'(S_MAX)) begin
      sat = S_MAX;
    end else if (sum < EXT_W'(S_MIN)) begin
      sat = S_MIN;
    end else begin
      sat = STATE_WIDTH'(sum);
    end
    leaked = state - (state >>> leak_shift);
  end

  always_comb begin
    next_state_c = state;
    fire_c       = 1'b0;
    case (op)
      INTEGRATE: begin
        if (sat >= threshold) begin
          fire_c       = 1'b1;
          next_state_c = '0;
        end else begin
          next_state_c = sat;
        end
      end
      LEAK:    next_state_c = leaked;
      CLEAR:   next_state_c = '0;
      default: next_state_c = state;
    endcase
  end

endmodule

// File: rtl/synch_neuron_cluster.sv
// Cluster of LIF neurons fed by a one-entry event stage (S1) and draining
// spikes through a single registered output slot with valid/ready handshake.
module synch_neuron_cluster
  import synch_neuron_pkg::*;
#(
  parameter int unsigned N_NEURONS        = 16,
  parameter int unsigned STATE_WIDTH      = 16,
  parameter int unsigned SYN_WEIGHT_WIDTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          evt_valid_i,
  output logic                          evt_ready_o,
  input  logic [$clog2(N_NEURONS)-1:0]  evt_addr_i,
  input  logic [1:0]                    evt_op_i,
  input  logic signed [SYN_WEIGHT_WIDTH-1:0] syn_weight_i,
  input  logic [2:0]                    syn_weight_scale_i,
  input  logic signed [STATE_WIDTH-1:0] threshold_i,
  input  logic [3:0]                    leak_shift_i,
  output logic                          spike_valid_o,
  input  logic                          spike_ready_i,
  output logic [$clog2(N_NEURONS)-1:0]  spike_addr_o
);

  localparam int unsigned ADDR_W = $clog2(N_NEURONS);

  logic signed [STATE_WIDTH-1:0] mem [N_NEURONS];

  logic                          s1_valid;
  evt_t                          s1_evt;
  logic [ADDR_W-1:0]             s1_addr;
  logic signed [STATE_WIDTH-1:0] s1_state;
  logic signed [STATE_WIDTH-1:0] upd_state;
  logic                          upd_fire;
  logic                          s1_stall;
  logic                          s1_advance;
  logic                          accept;

  // The state array is written at the edge that retires S1, so the next
  // event read in S1 always sees the previous write without forwarding.
  assign s1_addr  = ADDR_W'(s1_evt.addr);
  assign s1_state = mem[s1_addr];

  lif_update #(
    .STATE_WIDTH (STATE_WIDTH)
  ) u_lif (
    .state        (s1_state),
    .op           (s1_evt.op),
    .weight       (s1_evt.weight),
    .scale        (s1_evt.scale),
    .threshold    (threshold_i),
    .leak_shift   (leak_shift_i),
    .next_state_c (upd_state),
    .fire_c       (upd_fire)
  );

  // S1 only waits when its spike cannot be placed in the output slot.
  always_comb begin
    s1_stall    = s1_valid && upd_fire && spike_valid_o && !spike_ready_i;
    s1_advance  = s1_valid && !s1_stall;
    evt_ready_o = rst_ni && !clear_i && !s1_stall;
    accept      = evt_valid_i && evt_ready_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_evt   <= '0;
    end else if (clear_i) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_evt   <= '{addr:   MAX_ADDR_W'(evt_addr_i),
                    op:     op_e'(evt_op_i),
                    weight: MAX_WEIGHT_W'(syn_weight_i),
                    scale:  syn_weight_scale_i};
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < N_NEURONS; i++) mem[i] <= '0;
    end else if (clear_i) begin
      for (int unsigned i = 0; i < N_NEURONS; i++) mem[i] <= '0;
    end else if (s1_advance) begin
      mem[s1_addr] <= upd_state;
    end
  end

  // A drain and a new spike in the same cycle reload the slot directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spike_valid_o <= 1'b0;
      spike_addr_o  <= '0;
    end else if (clear_i) begin
      spike_valid_o <= 1'b0;
      spike_addr_o  <= '0;
    end else if (s1_advance && upd_fire) begin
      spike_valid_o <= 1'b1;
      spike_addr_o  <= s1_addr;
    end else if (spike_ready_i) begin
      spike_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_synch_neuron_cluster.sv
// Bench for synch_neuron_cluster: directed scenarios plus a random event
// stream, checked against an arithmetic per-neuron model.
module tb_synch_neuron_cluster;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_addr;
  logic [1:0]  evt_op;
  logic [3:0]  syn_weight;
  logic [2:0]  scale;
  logic [15:0] threshold;
  logic [3:0]  leak_shift;
  logic        spike_valid;
  logic        spike_ready;
  logic [3:0]  spike_addr;

  always #5 clk = ~clk;

  synch_neuron_cluster #(
    .N_NEURONS        (16),
    .STATE_WIDTH      (16),
    .SYN_WEIGHT_WIDTH (4)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .clear_i            (clear),
    .evt_valid_i        (evt_valid),
    .evt_ready_o        (evt_ready),
    .evt_addr_i         (evt_addr),
    .evt_op_i           (evt_op),
    .syn_weight_i       (syn_weight),
    .syn_weight_scale_i (scale),
    .threshold_i        (threshold),
    .leak_shift_i       (leak_shift),
    .spike_valid_o      (spike_valid),
    .spike_ready_i      (spike_ready),
    .spike_addr_o       (spike_addr)
  );

  int checks = 0;
  int errors = 0;
  int model [16];
  int thr;
  int lsh;
  bit pend_fire;
  bit pend_v;
  int pend_addr;
  int pend_val;
  int spikes_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input int a, input int v);
    chk(tag, {16'h0, dut.mem[a]}, {16'h0, 16'(v)});
  endtask

  function automatic int sat16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int floor_div(input int v, input int d);
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  // Reference behaviour of one event; returns whether the neuron fires.
  function automatic bit model_apply(input int a, input int op, input int w, input int sc);
    int s;
    bit f;
    f = 1'b0;
    case (op)
      0: begin
        s = sat16(model[a] + w * (1 << sc));
        if (s >= thr) begin
          f = 1'b1;
          model[a] = 0;
        end else begin
          model[a] = s;
        end
      end
      1: model[a] = model[a] - floor_div(model[a], 1 << lsh);
      2: model[a] = 0;
      default: ;
    endcase
    return f;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 16; i++) model[i] = 0;
  endtask

  task automatic reset_pend();
    pend_fire = 1'b0;
    pend_v    = 1'b0;
    pend_addr = 0;
    pend_val  = 0;
  endtask

  task automatic set_cfg(input int t, input int l);
    thr        = t;
    lsh        = l;
    threshold  = 16'(t);
    leak_shift = 4'(l);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int a, input int op, input int w, input int sc);
    evt_valid  = v;
    evt_addr   = 4'(a);
    evt_op     = 2'(op);
    syn_weight = 4'(w);
    scale      = 3'(sc);
  endtask

  // One cycle with the output never back-pressured: the spike and state of
  // the event accepted one edge earlier become visible after this edge.
  task automatic step_evt(input bit v, input int a, input int op, input int w, input int sc);
    bit f;
    drive(v, a, op, w, sc);
    #1 chk("evt_ready", 32'(evt_ready), 32'd1);
    @(posedge clk);
    f = v ? model_apply(a, op, w, sc) : 1'b0;
    #1;
    chk("spike_valid", 32'(spike_valid), 32'(pend_fire));
    if (pend_fire) chk("spike_addr", 32'(spike_addr), 32'(pend_addr));
    if (pend_v) chk_mem("state", pend_addr, pend_val);
    if (spike_valid) spikes_seen++;
    pend_fire = f;
    pend_v    = v;
    pend_addr = a;
    pend_val  = model[a];
    evt_valid = 1'b0;
  endtask

  task automatic flush();
    step_evt(1'b0, 0, 3, 0, 0);
  endtask

  // Build up a target state using repeated INTEGRATE events of weight w.
  task automatic ramp(input int a, input int w, input int total);
    int units;
    int sc;
    units = total / w;
    while (units > 0) begin
      sc = 7;
      while ((1 << sc) > units) sc--;
      step_evt(1'b1, a, 0, w, sc);
      units -= (1 << sc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    clear       = 1'b0;
    spike_ready = 1'b1;
    spikes_seen = 0;
    drive(1'b0, 0, 3, 0, 0);
    set_cfg(10, 2);
    model_zero();
    reset_pend();

    // Reset state
    #12;
    chk("rst_evt_ready", 32'(evt_ready), 32'd0);
    chk("rst_spike_valid", 32'(spike_valid), 32'd0);
    chk("rst_spike_addr", 32'(spike_addr), 32'd0);
    chk_mem("rst_state", 3, 0);
    tick();
    rst_n = 1'b1;
    #1 chk("ready_after_reset", 32'(evt_ready), 32'd1);

    // Three integrates reach the threshold on the third event
    for (int i = 0; i < 3; i++) step_evt(1'b1, 3, 0, 2, 1);
    flush();
    chk("basic_spike_valid", 32'(spike_valid), 32'd1);
    chk("basic_spike_addr", 32'(spike_addr), 32'd3);
    chk_mem("basic_state", 3, 0);
    flush();

    // Positive saturation fires, negative saturation clamps silently
    set_cfg(32767, 2);
    step_evt(1'b1, 0, 2, 0, 0);
    ramp(0, 7, 32760);
    flush();
    chk_mem("sat_pos_pre", 0, 32760);
    step_evt(1'b1, 0, 0, 7, 7);
    flush();
    chk("sat_pos_spike", 32'(spike_valid), 32'd1);
    chk_mem("sat_pos_state", 0, 0);
    flush();
    ramp(0, -8, -32760);
    flush();
    chk_mem("sat_neg_pre", 0, -32760);
    step_evt(1'b1, 0, 0, -8, 7);
    flush();
    chk("sat_neg_no_spike", 32'(spike_valid), 32'd0);
    chk_mem("sat_neg_state", 0, -32768);

    // Leak in both signs and with a zero shift
    spikes_seen = 0;
    step_evt(1'b1, 9, 2, 0, 0);
    ramp(9, 4, 100);
    step_evt(1'b1, 9, 1, 0, 0);
    flush();
    chk_mem("leak_pos", 9, 75);
    step_evt(1'b1, 9, 2, 0, 0);
    ramp(9, -4, -100);
    step_evt(1'b1, 9, 1, 0, 0);
    flush();
    chk_mem("leak_neg", 9, -75);
    set_cfg(32767, 0);
    step_evt(1'b1, 9, 1, 0, 0);
    flush();
    chk_mem("leak_shift0", 9, 0);
    chk("leak_no_spikes", 32'(spikes_seen), 32'd0);

    // Streaming one event per cycle
    set_cfg(4, 2);
    step_evt(1'b1, 5, 2, 0, 0);
    flush();
    spikes_seen = 0;
    for (int i = 0; i < 12; i++) step_evt(1'b1, 5, 0, 1, 0);
    flush();
    chk("stream_spikes", 32'(spikes_seen), 32'd3);

    // Output back-pressure with two firing events
    set_cfg(2, 2);
    step_evt(1'b1, 1, 2, 0, 0);
    step_evt(1'b1, 2, 2, 0, 0);
    step_evt(1'b1, 2, 0, 1, 0);
    flush();
    spike_ready = 1'b0;
    drive(1'b1, 1, 0, 2, 0);
    #1 chk("bp_ready1", 32'(evt_ready), 32'd1);
    @(posedge clk);
    void'(model_apply(1, 0, 2, 0));
    #1 drive(1'b1, 2, 0, 2, 0);
    #1 chk("bp_ready2", 32'(evt_ready), 32'd1);
    @(posedge clk);
    void'(model_apply(2, 0, 2, 0));
    #1 evt_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_hold_valid", 32'(spike_valid), 32'd1);
      chk("bp_hold_addr", 32'(spike_addr), 32'd1);
      chk("bp_hold_ready", 32'(evt_ready), 32'd0);
      chk_mem("bp_hold_state2", 2, 1);
      tick();
    end
    spike_ready = 1'b1;
    #1 chk("bp_ready_return", 32'(evt_ready), 32'd1);
    tick();
    chk("bp_second_valid", 32'(spike_valid), 32'd1);
    chk("bp_second_addr", 32'(spike_addr), 32'd2);
    chk_mem("bp_state1", 1, 0);
    chk_mem("bp_state2", 2, 0);
    tick();
    chk("bp_drained", 32'(spike_valid), 32'd0);
    reset_pend();

    // Clear with an event in S1 and a spike pending
    step_evt(1'b1, 7, 0, 1, 0);
    flush();
    spike_ready = 1'b0;
    drive(1'b1, 1, 0, 2, 0);
    tick();
    drive(1'b1, 4, 0, 1, 0);
    tick();
    evt_valid = 1'b0;
    chk("clr_pre_spike", 32'(spike_valid), 32'd1);
    clear = 1'b1;
    drive(1'b1, 6, 0, 1, 0);
    #1 chk("clr_ready", 32'(evt_ready), 32'd0);
    tick();
    clear       = 1'b0;
    evt_valid   = 1'b0;
    spike_ready = 1'b1;
    model_zero();
    chk("clr_spike_valid", 32'(spike_valid), 32'd0);
    for (int a = 0; a < 16; a++) chk_mem("clr_state", a, model[a]);
    #1 chk("clr_ready_after", 32'(evt_ready), 32'd1);
    tick();
    chk("clr_no_late_spike", 32'(spike_valid), 32'd0);
    chk_mem("clr_s1_dropped", 4, 0);
    chk_mem("clr_evt_dropped", 6, 0);
    reset_pend();

    // Reset asserted mid-stream
    step_evt(1'b1, 8, 0, 1, 0);
    flush();
    spike_ready = 1'b0;
    drive(1'b1, 1, 0, 2, 0);
    tick();
    drive(1'b1, 2, 0, 2, 0);
    tick();
    evt_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_evt_ready", 32'(evt_ready), 32'd0);
    chk("mid_rst_spike_valid", 32'(spike_valid), 32'd0);
    chk("mid_rst_spike_addr", 32'(spike_addr), 32'd0);
    chk_mem("mid_rst_state", 8, 0);
    tick();
    rst_n       = 1'b1;
    spike_ready = 1'b1;
    model_zero();
    reset_pend();
    #1 chk("mid_rst_ready_after", 32'(evt_ready), 32'd1);
    chk("mid_rst_no_spike", 32'(spike_valid), 32'd0);

    // Random event stream against the model
    set_cfg(int'($urandom_range(20, 300)), int'($urandom_range(1, 4)));
    for (int i = 0; i < 400; i++) begin
      int r;
      int op;
      r  = int'($urandom_range(0, 8));
      op = (r < 6) ? 0 : r - 5;
      step_evt(($urandom_range(0, 4) != 0), int'($urandom_range(0, 15)), op,
               int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 7)));
    end
    flush();
    for (int a = 0; a < 16; a++) chk_mem("rand_final_state", a, model[a]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/synch_neuron_cluster.md
SYNCH_NEURON_CLUSTER -- requirements
Module: synch_neuron_cluster

Interface
REQ-001 SHALL have parameter N_NEURONS, default 16: neuron count; power of two, 2..256.
REQ-002 SHALL have parameter STATE_WIDTH, default 16: signed membrane state width.
REQ-003 SHALL have parameter SYN_WEIGHT_WIDTH, default 4: signed synaptic weight width.
REQ-004 SHALL have port clk_i  input  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni  input  1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port clear_i  input  1: synchronous wipe of all neuron states.
REQ-007 SHALL have port evt_valid_i  input  1: input event valid.
REQ-008 SHALL have port evt_ready_o  output  1: input event accepted when valid and ready.
REQ-009 SHALL have port evt_addr_i  input  $clog2(N_NEURONS): target neuron.
REQ-010 SHALL have port evt_op_i  input  2: 0 INTEGRATE, 1 LEAK, 2 CLEAR, 3 NOP.
REQ-011 SHALL have port syn_weight_i  input  SYN_WEIGHT_WIDTH: signed weight.
REQ-012 SHALL have port syn_weight_scale_i  input  3: left-shift for the weight.
REQ-013 SHALL have port threshold_i  input  STATE_WIDTH: signed firing threshold, static during operation.
REQ-014 SHALL have port leak_shift_i  input  4: leak arithmetic right-shift, static.
REQ-015 SHALL have port spike_valid_o  output  1: output spike event valid.
REQ-016 SHALL have port spike_ready_i  input  1: downstream ready.
REQ-017 SHALL have port spike_addr_o  output  $clog2(N_NEURONS): index of the neuron that fired.

Function
REQ-018 SHALL hold N_NEURONS state registers; stage S1 holds at most one accepted event; the output register holds at most one spike.
REQ-019 SHALL, for an event accepted at edge k, read the state in S1, write the updated state at edge k+1, and raise spike_valid_o after edge k+1 if the neuron fired.
REQ-020 INTEGRATE SHALL compute v + (sign-extended syn_weight_i <<< scale), saturating to the signed STATE_WIDTH range.
REQ-021 INTEGRATE SHALL fire when the saturated result >= threshold_i (signed); the stored state then becomes 0.
REQ-022 LEAK SHALL store v - (v >>> leak_shift_i) and never fire; a shift of 0 yields 0.
REQ-023 CLEAR SHALL store 0 and never fire; NOP SHALL leave the state unchanged and never fire.
REQ-024 Back-to-back events to the same address SHALL each observe the previous write, with no bubble and no forwarding error.
REQ-025 S1 SHALL stall only while its event fires, spike_valid_o=1 and spike_ready_i=0; evt_ready_o = !S1 valid or S1 advances.
REQ-026 spike_valid_o and spike_addr_o SHALL remain stable until spike_ready_i=1; a drain and a new spike in the same cycle SHALL load the new spike with no gap.
REQ-027 Throughput SHALL be one event per cycle while the output is not back-pressured.
REQ-028 clear_i SHALL, at the next edge, zero all states, invalidate S1 and the output register, and drop any event presented that cycle; clear_i takes precedence over all ops.
REQ-029 evt_ready_o SHALL be 0 during a clear_i cycle.

Reset
REQ-030 While rst_ni=0: all states 0, S1 invalid, spike_valid_o=0, spike_addr_o=0, evt_ready_o=0.
REQ-031 After reset release: evt_ready_o=1 in the first cycle; reset asserted mid-operation discards all in-flight events and spikes.

Structure
REQ-032 Package synch_neuron_pkg SHALL define the op enum (INTEGRATE, LEAK, CLEAR, NOP) and the event struct (addr, op, weight, scale).
REQ-033 Sub-module lif_update (combinational: state, op, weight, scale, threshold, leak shift -> next state, fire) SHALL hold all arithmetic; the state array and handshakes stay in synch_neuron_cluster.

Verification
REQ-034 threshold=10, three INTEGRATE events to addr 3 with weight 2, scale 1 -> spike on addr 3 one cycle after the third event; state(3)=0 afterwards.
REQ-035 Neuron at 32760 (STATE_WIDTH=16), INTEGRATE weight 7, scale 7, threshold 32767 -> saturates at 32767, fires, stored 0; weight -8 from -32760 -> clamps at -32768, no spike.
REQ-036 State 100, LEAK with shift 2 -> 75; state -100, shift 2 -> -75; shift 0 -> 0; spike_valid_o never asserts.
REQ-037 Hold spike_ready_i=0 while two firing events target addrs 1 and 2 -> first spike held stable, evt_ready_o drops, second spike follows 1 cycle after ready returns; no spike lost.
REQ-038 Streaming events to addr 5 every cycle with weight 1, threshold 4 -> spike every 4th event, one event accepted per cycle.
REQ-039 Assert clear_i with one event in S1 and one spike pending -> next cycle all states 0, spike_valid_o=0; assert rst_ni=0 mid-stream -> outputs match REQ-030 immediately.
